// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access sizes,
// controller states and the wait-state counter width.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'b00,
        SZ_HALF   = 2'b01,
        SZ_WORD   = 2'b10,
        SZ_DOUBLE = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a load/store unit and data_mem_ctrl.
interface data_mem_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl_align.sv
// Byte-lane alignment: load extract/extend, store byte merge and the
// alignment/size legality check. Purely combinational.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  size_e                               size,
    input  logic                                is_signed,
    input  logic [$clog2(DATA_W/8)-1:0]         off,
    input  logic [DATA_W-1:0]                   old_word,
    input  logic [DATA_W-1:0]                   wdata,
    output logic [DATA_W-1:0]                   load_data,
    output logic [DATA_W-1:0]                   store_word,
    output logic                                align_err
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    int unsigned       nbytes;
    int unsigned       nbits;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] wsh;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] top;
    logic              sign;
    logic [NB-1:0]     be;

    // Shift the addressed lanes to bit 0 for loads and up to the lane for stores.
    always_comb begin
        nbytes = 32'(1) << size;
        nbits  = nbytes * 8;
        sh     = old_word >> {off, 3'b000};
        wsh    = wdata << {off, 3'b000};
        // shifting by >= width yields zero, so a full-width access gets an all-ones mask
        mask   = ~({DATA_W{1'b1}} << nbits);
        top    = mask & ~(mask >> 1);
        sign   = is_signed && (|(sh & top));
        load_data = (sh & mask) | (sign ? ~mask : '0);
        be     = (~({NB{1'b1}} << nbytes)) << off;
        store_word = old_word;
        for (int unsigned k = 0; k < NB; k++) begin
            if (be[k]) begin
                store_word[8*k +: 8] = wsh[8*k +: 8];
            end
        end
        align_err = ((off & OFF_W'(nbytes - 1)) != '0) || (nbits > DATA_W);
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory with valid/ready request bus, configurable wait states,
// sub-word access with extension and error reporting.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_ctrl_if.slave bus
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e              state_q,     state_d;
    logic [WAIT_W-1:0]   cnt_q,       cnt_d;
    logic                write_q,     write_d;
    size_e               size_q,      size_d;
    logic                signed_q,    signed_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [ADDR_W-1:0]   word_idx_full;
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   old_word;
    logic [DATA_W-1:0]   load_data;
    logic [DATA_W-1:0]   store_word;
    logic                align_err;
    logic                acc_err;
    logic                commit;
    logic                mem_we;

    // Decode the captured address and decide whether the access is legal.
    always_comb begin
        word_idx_full = addr_q >> OFF_W;
        in_range      = word_idx_full < ADDR_W'(DEPTH);
        idx           = IDX_W'(word_idx_full);
        old_word      = in_range ? mem[idx] : '0;
        acc_err       = align_err || !in_range;
        commit        = (state_q == BUSY) && (cnt_q == '0);
        mem_we        = commit && write_q && !acc_err;
    end

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size       (size_q),
        .is_signed  (signed_q),
        .off        (addr_q[OFF_W-1:0]),
        .old_word   (old_word),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word),
        .align_err  (align_err)
    );

    // Next-state, capture and response computation for the request FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d     = bus.req_write;
                    size_d      = size_e'(bus.req_size);
                    signed_d    = bus.req_signed;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    cnt_d       = WAIT_W'(WAIT_STATES);
                    req_ready_d = 1'b0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err;
                    rsp_rdata_d = (acc_err || write_q) ? '0 : load_data;
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
        endcase
    end

    // FSM, counter, capture and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= store_word;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: 32-bit builds with 1, 0 and 4 wait
// states plus a 64-bit build.
module tb_data_mem_ctrl;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c, rst_d;

    data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
    data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus_b ();
    data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus_c ();
    data_mem_ctrl_if #(.DATA_W(64), .ADDR_W(32)) bus_d ();

    data_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(128), .WAIT_STATES(1))
        dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
    data_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(128), .WAIT_STATES(0))
        dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));
    data_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(128), .WAIT_STATES(4))
        dut_c (.clk(clk), .reset(rst_c), .bus(bus_c));
    data_mem_ctrl #(.DATA_W(64), .ADDR_W(32), .DEPTH(128), .WAIT_STATES(1))
        dut_d (.clk(clk), .reset(rst_d), .bus(bus_d));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t vecs [26];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic v, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [63:0] wd);
        case (which)
            0: begin
                bus_a.req_valid = v; bus_a.req_write = wr; bus_a.req_size = sz;
                bus_a.req_signed = sg; bus_a.req_addr = addr; bus_a.req_wdata = wd[31:0];
            end
            1: begin
                bus_b.req_valid = v; bus_b.req_write = wr; bus_b.req_size = sz;
                bus_b.req_signed = sg; bus_b.req_addr = addr; bus_b.req_wdata = wd[31:0];
            end
            2: begin
                bus_c.req_valid = v; bus_c.req_write = wr; bus_c.req_size = sz;
                bus_c.req_signed = sg; bus_c.req_addr = addr; bus_c.req_wdata = wd[31:0];
            end
            default: begin
                bus_d.req_valid = v; bus_d.req_write = wr; bus_d.req_size = sz;
                bus_d.req_signed = sg; bus_d.req_addr = addr; bus_d.req_wdata = wd;
            end
        endcase
    endtask

    task automatic sample(input int which, output logic rdy, output logic rv,
                          output logic [63:0] rd, output logic er);
        case (which)
            0: begin rdy = bus_a.req_ready; rv = bus_a.rsp_valid; rd = {32'h0, bus_a.rsp_rdata}; er = bus_a.rsp_err; end
            1: begin rdy = bus_b.req_ready; rv = bus_b.rsp_valid; rd = {32'h0, bus_b.rsp_rdata}; er = bus_b.rsp_err; end
            2: begin rdy = bus_c.req_ready; rv = bus_c.rsp_valid; rd = {32'h0, bus_c.rsp_rdata}; er = bus_c.rsp_err; end
            default: begin rdy = bus_d.req_ready; rv = bus_d.rsp_valid; rd = bus_d.rsp_rdata; er = bus_d.rsp_err; end
        endcase
    endtask

    // One complete request: wait for ready, hand over, await the one-cycle response.
    task automatic txn(input int which, input string name, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input logic exp_err, input int exp_lat);
        logic        rdy, rv, er;
        logic [63:0] rd;
        int          n;
        bit          got;
        @(negedge clk);
        drive(which, 1'b1, wr, sz, sg, addr, wd);
        n = 0;
        sample(which, rdy, rv, rd, er);
        while (!rdy && n < 50) begin
            @(negedge clk);
            sample(which, rdy, rv, rd, er);
            n++;
        end
        check({name, "_accept"}, 64'(rdy), 64'(1));
        @(negedge clk);
        drive(which, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 64'h0);
        n   = 1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            sample(which, rdy, rv, rd, er);
            if (rv) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check({name, "_rsp"}, 64'(got), 64'(1));
        if (got) begin
            check({name, "_lat"}, 64'(n), 64'(exp_lat));
            check({name, "_rdata"}, rd, exp_rd);
            check({name, "_err"}, 64'(er), 64'(exp_err));
            @(negedge clk);
            sample(which, rdy, rv, rd, er);
            check({name, "_pulse"}, 64'(rv), 64'(0));
            check({name, "_ready"}, 64'(rdy), 64'(1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic        rdy, rv, er;
        logic [63:0] rd;

        vecs[0]  = '{1'b1, SZ_WORD,   1'b0, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, SZ_WORD,   1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, SZ_BYTE,   1'b0, 32'h012, 32'h0000005A, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, SZ_WORD,   1'b0, 32'h010, 32'h0,        32'hDE5ABEEF, 1'b0};
        vecs[4]  = '{1'b0, SZ_BYTE,   1'b1, 32'h013, 32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[5]  = '{1'b0, SZ_BYTE,   1'b0, 32'h013, 32'h0,        32'h000000DE, 1'b0};
        vecs[6]  = '{1'b0, SZ_HALF,   1'b0, 32'h011, 32'h0,        32'h00000000, 1'b1};
        vecs[7]  = '{1'b1, SZ_WORD,   1'b0, 32'h000, 32'h11223344, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b1, SZ_WORD,   1'b0, 32'h200, 32'h55555555, 32'h00000000, 1'b1};
        vecs[9]  = '{1'b0, SZ_WORD,   1'b0, 32'h000, 32'h0,        32'h11223344, 1'b0};
        vecs[10] = '{1'b0, SZ_WORD,   1'b0, 32'h200, 32'h0,        32'h00000000, 1'b1};
        vecs[11] = '{1'b1, SZ_HALF,   1'b0, 32'h002, 32'h0000ABCD, 32'h00000000, 1'b0};
        vecs[12] = '{1'b0, SZ_WORD,   1'b0, 32'h000, 32'h0,        32'hABCD3344, 1'b0};
        vecs[13] = '{1'b1, SZ_WORD,   1'b0, 32'h002, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[14] = '{1'b0, SZ_WORD,   1'b0, 32'h000, 32'h0,        32'hABCD3344, 1'b0};
        vecs[15] = '{1'b0, SZ_DOUBLE, 1'b0, 32'h000, 32'h0,        32'h00000000, 1'b1};
        vecs[16] = '{1'b0, SZ_HALF,   1'b1, 32'h012, 32'h0,        32'hFFFFDE5A, 1'b0};
        vecs[17] = '{1'b0, SZ_HALF,   1'b0, 32'h010, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[18] = '{1'b1, SZ_WORD,   1'b0, 32'h1FC, 32'hCAFEF00D, 32'h00000000, 1'b0};
        vecs[19] = '{1'b0, SZ_BYTE,   1'b1, 32'h1FD, 32'h0,        32'hFFFFFFF0, 1'b0};
        vecs[20] = '{1'b0, SZ_WORD,   1'b0, 32'h1FC, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[21] = '{1'b1, SZ_BYTE,   1'b0, 32'h010, 32'hFFFFFF77, 32'h00000000, 1'b0};
        vecs[22] = '{1'b0, SZ_WORD,   1'b0, 32'h010, 32'h0,        32'hDE5ABE77, 1'b0};
        vecs[23] = '{1'b0, SZ_HALF,   1'b0, 32'h1FE, 32'h0,        32'h0000CAFE, 1'b0};
        vecs[24] = '{1'b1, SZ_HALF,   1'b0, 32'h003, 32'h00001234, 32'h00000000, 1'b1};
        vecs[25] = '{1'b0, SZ_WORD,   1'b0, 32'h000, 32'h0,        32'hABCD3344, 1'b0};

        for (int w = 0; w < 4; w++) drive(w, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 64'h0);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        repeat (2) @(negedge clk);

        sample(0, rdy, rv, rd, er);
        check("reset_ready", 64'(rdy), 64'(1));
        check("reset_rsp_valid", 64'(rv), 64'(0));
        check("reset_rdata", rd, 64'h0);
        check("reset_err", 64'(er), 64'(0));

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 26; i++) begin
            txn(0, $sformatf("a_vec%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr,
                {32'h0, vecs[i].wd}, {32'h0, vecs[i].rd}, vecs[i].err, 3);
        end

        // Back-to-back with req_valid held: IDLE, BUSY, RESP repeating.
        @(negedge clk);
        drive(1, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h0, 64'h600D);
        for (int i = 0; i < 12; i++) begin
            sample(1, rdy, rv, rd, er);
            check($sformatf("b_ready%0d", i), 64'(rdy), 64'((i % 3) == 0));
            check($sformatf("b_rsp%0d", i), 64'(rv), 64'((i % 3) == 2));
            @(negedge clk);
        end
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 64'h0);
        txn(1, "b_load", 1'b0, SZ_WORD, 1'b0, 32'h0, 64'h0, 64'h600D, 1'b0, 2);

        // Reset one cycle into a store: no response, store abandoned.
        txn(2, "c_store", 1'b1, SZ_WORD, 1'b0, 32'h20, 64'h11111111, 64'h0, 1'b0, 6);
        @(negedge clk);
        drive(2, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h20, 64'h22222222);
        @(negedge clk);
        drive(2, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 64'h0);
        rst_c = 1'b1;
        @(negedge clk);
        rst_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample(2, rdy, rv, rd, er);
            check($sformatf("c_no_rsp%0d", i), 64'(rv), 64'(0));
            check($sformatf("c_ready%0d", i), 64'(rdy), 64'(1));
            @(negedge clk);
        end
        txn(2, "c_load", 1'b0, SZ_WORD, 1'b0, 32'h20, 64'h0, 64'h11111111, 1'b0, 6);

        // 64-bit build.
        txn(3, "d_st_dbl",  1'b1, SZ_DOUBLE, 1'b0, 32'h08, 64'h0123456789ABCDEF, 64'h0, 1'b0, 3);
        txn(3, "d_ld_hs_e", 1'b0, SZ_HALF,   1'b1, 32'h0E, 64'h0, 64'h0000000000000123, 1'b0, 3);
        txn(3, "d_ld_dbl",  1'b0, SZ_DOUBLE, 1'b0, 32'h08, 64'h0, 64'h0123456789ABCDEF, 1'b0, 3);
        txn(3, "d_ld_wu",   1'b0, SZ_WORD,   1'b0, 32'h08, 64'h0, 64'h0000000089ABCDEF, 1'b0, 3);
        txn(3, "d_ld_ws",   1'b0, SZ_WORD,   1'b1, 32'h08, 64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0, 3);
        txn(3, "d_ld_ws_c", 1'b0, SZ_WORD,   1'b1, 32'h0C, 64'h0, 64'h0000000001234567, 1'b0, 3);
        txn(3, "d_ld_mis",  1'b0, SZ_DOUBLE, 1'b0, 32'h04, 64'h0, 64'h0, 1'b1, 3);
        txn(3, "d_ld_oor",  1'b0, SZ_DOUBLE, 1'b0, 32'h400, 64'h0, 64'h0, 1'b1, 3);
        txn(3, "d_st_w",    1'b1, SZ_WORD,   1'b0, 32'h0C, 64'hFFFFFFFF, 64'h0, 1'b0, 3);
        txn(3, "d_ld_dbl2", 1'b0, SZ_DOUBLE, 1'b0, 32'h08, 64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0, 3);
        txn(3, "d_ld_bs",   1'b0, SZ_BYTE,   1'b1, 32'h0F, 64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
